// File: rtl/regfile_np.sv
// regfile_np: parametrised multi-port register file with combinational reads and optional write bypass.
// Latency: write 1 cycle, read 0 cycles; no backpressure, every cycle is accepted.
module regfile_np #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr [0:NRD-1],
  output logic [WIDTH-1:0]  rdata [0:NRD-1],
  output logic              wr_err,
  output logic [NRD-1:0]    rd_err
);

  // One extra bit so DEPTH itself is representable for power-of-two depths.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic             w_in_range;
  logic             wr_legal;

  assign w_in_range = ({1'b0, waddr} < DEPTH_W);
  // Writes to the hardwired-zero entry are dropped silently, not flagged.
  assign wr_legal   = we && w_in_range && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= we && !w_in_range;
      if (wr_legal) mem[waddr] <= wdata;
    end
  end

  // Range check comes first so an unbacked address never indexes storage.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rdata[i]  = '0;
      rd_err[i] = 1'b0;
      if ({1'b0, raddr[i]} >= DEPTH_W) begin
        rd_err[i] = 1'b1;
      end else if ((ZERO_REG != 0) && (raddr[i] == '0)) begin
        rdata[i] = '0;
      end else if ((BYPASS != 0) && wr_legal && !rst && (waddr == raddr[i])) begin
        rdata[i] = wdata;
      end else begin
        rdata[i] = mem[raddr[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_np.sv
// Directed bench for regfile_np across four parameter sets sharing one clock and reset.
module tb_regfile_np;
  logic clk;
  logic rst;
  int total;
  int bad;

  // u0: defaults
  logic        we0;
  logic [4:0]  waddr0;
  logic [31:0] wdata0;
  logic [4:0]  raddr0 [0:1];
  logic [31:0] rdata0 [0:1];
  logic        wr_err0;
  logic [1:0]  rd_err0;
  // u1: ZERO_REG=0, BYPASS=0
  logic        we1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic [4:0]  raddr1 [0:1];
  logic [31:0] rdata1 [0:1];
  logic        wr_err1;
  logic [1:0]  rd_err1;
  // u2: DEPTH=24
  logic        we2;
  logic [4:0]  waddr2;
  logic [31:0] wdata2;
  logic [4:0]  raddr2 [0:1];
  logic [31:0] rdata2 [0:1];
  logic        wr_err2;
  logic [1:0]  rd_err2;
  // u3: NRD=4, WIDTH=16
  logic        we3;
  logic [4:0]  waddr3;
  logic [15:0] wdata3;
  logic [4:0]  raddr3 [0:3];
  logic [15:0] rdata3 [0:3];
  logic        wr_err3;
  logic [3:0]  rd_err3;

  logic [15:0] model_mem [0:31];

  regfile_np u0 (.clk(clk), .rst(rst), .we(we0), .waddr(waddr0), .wdata(wdata0),
                 .raddr(raddr0), .rdata(rdata0), .wr_err(wr_err0), .rd_err(rd_err0));
  regfile_np #(.ZERO_REG(0), .BYPASS(0)) u1 (.clk(clk), .rst(rst), .we(we1), .waddr(waddr1),
                 .wdata(wdata1), .raddr(raddr1), .rdata(rdata1), .wr_err(wr_err1), .rd_err(rd_err1));
  regfile_np #(.DEPTH(24)) u2 (.clk(clk), .rst(rst), .we(we2), .waddr(waddr2), .wdata(wdata2),
                 .raddr(raddr2), .rdata(rdata2), .wr_err(wr_err2), .rd_err(rd_err2));
  regfile_np #(.NRD(4), .WIDTH(16)) u3 (.clk(clk), .rst(rst), .we(we3), .waddr(waddr3),
                 .wdata(wdata3), .raddr(raddr3), .rdata(rdata3), .wr_err(wr_err3), .rd_err(rd_err3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    raddr0[0] = 5'd5; raddr0[1] = 5'd6; raddr1[0] = 5'd0;
    #1;
    total++; if (rdata0[0] !== 32'h0) begin bad++; $display("FAIL reset_rd0 got=%h exp=%h", rdata0[0], 32'h0); end
    total++; if (rdata0[1] !== 32'h0) begin bad++; $display("FAIL reset_rd1 got=%h exp=%h", rdata0[1], 32'h0); end
    total++; if (wr_err0 !== 1'b0) begin bad++; $display("FAIL reset_wr_err got=%b exp=0", wr_err0); end
    total++; if (rd_err0 !== 2'b00) begin bad++; $display("FAIL reset_rd_err got=%b exp=00", rd_err0); end
    total++; if (rdata1[0] !== 32'h0) begin bad++; $display("FAIL reset_u1_rd0 got=%h exp=%h", rdata1[0], 32'h0); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    we0 = 1'b0; raddr0[0] = 5'd5; raddr0[1] = 5'd6;
    #1;
    total++; if (rdata0[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_p0 got=%h exp=%h", rdata0[0], 32'hDEADBEEF); end
    total++; if (rdata0[1] !== 32'h0) begin bad++; $display("FAIL wr_rd_p1 got=%h exp=%h", rdata0[1], 32'h0); end
    total++; if (wr_err0 !== 1'b0) begin bad++; $display("FAIL wr_rd_wr_err got=%b exp=0", wr_err0); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    @(negedge clk);
    we0 = 1'b0; raddr0[0] = 5'd0;
    we1 = 1'b0; raddr1[0] = 5'd0;
    #1;
    total++; if (rdata0[0] !== 32'h0) begin bad++; $display("FAIL zero_reg_on got=%h exp=%h", rdata0[0], 32'h0); end
    total++; if (wr_err0 !== 1'b0) begin bad++; $display("FAIL zero_reg_wr_err got=%b exp=0", wr_err0); end
    total++; if (rdata1[0] !== 32'hFFFFFFFF) begin bad++; $display("FAIL zero_reg_off got=%h exp=%h", rdata1[0], 32'hFFFFFFFF); end
    total++; if (wr_err1 !== 1'b0) begin bad++; $display("FAIL zero_reg_off_wr_err got=%b exp=0", wr_err1); end
    total++; if (rd_err1 !== 2'b00) begin bad++; $display("FAIL zero_reg_off_rd_err got=%b exp=00", rd_err1); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h11;
    @(negedge clk);
    wdata0 = 32'h22; wdata1 = 32'h22;
    raddr0[0] = 5'd7; raddr0[1] = 5'd7; raddr1[0] = 5'd7; raddr1[1] = 5'd8;
    #1;
    total++; if (rdata0[0] !== 32'h22) begin bad++; $display("FAIL bypass_on_p0 got=%h exp=%h", rdata0[0], 32'h22); end
    total++; if (rdata0[1] !== 32'h22) begin bad++; $display("FAIL bypass_on_p1 got=%h exp=%h", rdata0[1], 32'h22); end
    total++; if (rdata1[0] !== 32'h11) begin bad++; $display("FAIL bypass_off got=%h exp=%h", rdata1[0], 32'h11); end
    total++; if (rdata1[1] !== 32'h0) begin bad++; $display("FAIL bypass_off_other got=%h exp=%h", rdata1[1], 32'h0); end
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0;
    #1;
    total++; if (rdata0[0] !== 32'h22) begin bad++; $display("FAIL bypass_on_next got=%h exp=%h", rdata0[0], 32'h22); end
    total++; if (rdata1[0] !== 32'h22) begin bad++; $display("FAIL bypass_off_next got=%h exp=%h", rdata1[0], 32'h22); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    we2 = 1'b1; waddr2 = 5'd23; wdata2 = 32'hCAFE0023;
    raddr2[0] = 5'd23; raddr2[1] = 5'd24;
    #1;
    total++; if (rdata2[0] !== 32'hCAFE0023) begin bad++; $display("FAIL oor_last_bypass got=%h exp=%h", rdata2[0], 32'hCAFE0023); end
    total++; if (rdata2[1] !== 32'h0) begin bad++; $display("FAIL oor_rd24_data got=%h exp=%h", rdata2[1], 32'h0); end
    total++; if (rd_err2 !== 2'b10) begin bad++; $display("FAIL oor_rd24_err got=%b exp=10", rd_err2); end
    @(negedge clk);
    waddr2 = 5'd30; wdata2 = 32'h12345678;
    raddr2[0] = 5'd23; raddr2[1] = 5'd25;
    #1;
    total++; if (wr_err2 !== 1'b0) begin bad++; $display("FAIL oor_legal_wr_err got=%b exp=0", wr_err2); end
    total++; if (rdata2[0] !== 32'hCAFE0023) begin bad++; $display("FAIL oor_last_stored got=%h exp=%h", rdata2[0], 32'hCAFE0023); end
    total++; if (rdata2[1] !== 32'h0) begin bad++; $display("FAIL oor_rd25_data got=%h exp=%h", rdata2[1], 32'h0); end
    total++; if (rd_err2 !== 2'b10) begin bad++; $display("FAIL oor_rd25_err got=%b exp=10", rd_err2); end
    @(negedge clk);
    we2 = 1'b0; raddr2[0] = 5'd6; raddr2[1] = 5'd14;
    #1;
    total++; if (wr_err2 !== 1'b1) begin bad++; $display("FAIL oor_wr_err_set got=%b exp=1", wr_err2); end
    total++; if (rdata2[0] !== 32'h0) begin bad++; $display("FAIL oor_alias6 got=%h exp=%h", rdata2[0], 32'h0); end
    total++; if (rdata2[1] !== 32'h0) begin bad++; $display("FAIL oor_alias14 got=%h exp=%h", rdata2[1], 32'h0); end
    total++; if (rd_err2 !== 2'b00) begin bad++; $display("FAIL oor_in_range_err got=%b exp=00", rd_err2); end
    @(negedge clk);
    we2 = 1'b1; waddr2 = 5'd24; wdata2 = 32'h55;
    raddr2[0] = 5'd23; raddr2[1] = 5'd0;
    #1;
    total++; if (wr_err2 !== 1'b0) begin bad++; $display("FAIL oor_wr_err_pulse got=%b exp=0", wr_err2); end
    @(negedge clk);
    we2 = 1'b0;
    #1;
    total++; if (wr_err2 !== 1'b1) begin bad++; $display("FAIL oor_wr24_err got=%b exp=1", wr_err2); end
    total++; if (rdata2[0] !== 32'hCAFE0023) begin bad++; $display("FAIL oor_wr24_nochange got=%h exp=%h", rdata2[0], 32'hCAFE0023); end
  endtask

  task automatic test_reset_priority();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      we0 = 1'b1; waddr0 = 5'(k); wdata0 = 32'(k * 3);
    end
    @(negedge clk);
    we0 = 1'b0; raddr0[0] = 5'd31; raddr0[1] = 5'd3;
    #1;
    total++; if (rdata0[0] !== 32'd93) begin bad++; $display("FAIL rstp_fill31 got=%h exp=%h", rdata0[0], 32'd93); end
    total++; if (rdata0[1] !== 32'd9) begin bad++; $display("FAIL rstp_fill3 got=%h exp=%h", rdata0[1], 32'd9); end
    @(negedge clk);
    rst = 1'b1; we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hAA;
    raddr0[0] = 5'd3; raddr0[1] = 5'd3;
    we2 = 1'b1; waddr2 = 5'd30;
    #1;
    total++; if (rdata0[0] !== 32'd9) begin bad++; $display("FAIL rstp_no_bypass got=%h exp=%h", rdata0[0], 32'd9); end
    @(negedge clk);
    rst = 1'b0; we0 = 1'b0; we2 = 1'b0;
    #1;
    total++; if (wr_err0 !== 1'b0) begin bad++; $display("FAIL rstp_wr_err got=%b exp=0", wr_err0); end
    total++; if (wr_err2 !== 1'b0) begin bad++; $display("FAIL rstp_u2_wr_err got=%b exp=0", wr_err2); end
    for (int k = 0; k < 32; k++) begin
      raddr0[0] = 5'(k); raddr0[1] = 5'(31 - k);
      #1;
      total++; if (rdata0[0] !== 32'h0) begin bad++; $display("FAIL rstp_clear_p0 addr=%0d got=%h exp=%h", k, rdata0[0], 32'h0); end
      total++; if (rdata0[1] !== 32'h0) begin bad++; $display("FAIL rstp_clear_p1 addr=%0d got=%h exp=%h", 31 - k, rdata0[1], 32'h0); end
    end
  endtask

  task automatic test_multiport();
    logic [4:0]  a [0:3];
    logic [15:0] exp;
    bit dup;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      we3 = 1'b1; waddr3 = 5'(k); wdata3 = 16'(k) ^ 16'h5A5A;
      model_mem[k] = (k == 0) ? 16'h0 : (16'(k) ^ 16'h5A5A);
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      a[0] = 5'($urandom_range(31, 0));
      for (int j = 1; j < 4; j++) begin
        do begin
          a[j] = 5'($urandom_range(31, 0));
          dup = 1'b0;
          for (int m = 0; m < j; m++) if (a[m] == a[j]) dup = 1'b1;
        end while (dup);
      end
      we3 = 1'($urandom_range(1, 0)); waddr3 = 5'($urandom_range(31, 0)); wdata3 = 16'($urandom);
      for (int j = 0; j < 4; j++) raddr3[j] = a[j];
      #1;
      for (int j = 0; j < 4; j++) begin
        if (a[j] == 5'd0) exp = 16'h0;
        else if (we3 && waddr3 == a[j]) exp = wdata3;
        else exp = model_mem[a[j]];
        total++; if (rdata3[j] !== exp) begin bad++; $display("FAIL mp_cycle%0d_port%0d addr=%0d got=%h exp=%h", c, j, a[j], rdata3[j], exp); end
      end
      total++; if (rd_err3 !== 4'b0000 || wr_err3 !== 1'b0) begin bad++; $display("FAIL mp_err_cycle%0d got=%b/%b exp=0000/0", c, rd_err3, wr_err3); end
      if (we3 && waddr3 != 5'd0) model_mem[waddr3] = wdata3;
    end
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    we3 = 1'b0;
    for (int j = 0; j < 4; j++) raddr3[j] = 5'd9;
    #1;
    for (int j = 0; j < 4; j++) begin
      total++; if (rdata3[j] !== model_mem[9]) begin bad++; $display("FAIL same_addr_port%0d got=%h exp=%h", j, rdata3[j], model_mem[9]); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0; raddr0[0] = '0; raddr0[1] = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0; raddr1[0] = '0; raddr1[1] = '0;
    we2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2[0] = '0; raddr2[1] = '0;
    we3 = 1'b0; waddr3 = '0; wdata3 = '0;
    for (int j = 0; j < 4; j++) raddr3[j] = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_out_of_range();
    test_reset_priority();
    test_multiport();
    test_same_addr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_np.md
Name: regfile_np

Overview:
- Parametrised multi-port register file. Next generation of the team's 32-entry x 32-bit selection mux.
- The selection mux becomes the read path. It is generalised in width, depth and read-port count.
- Adds clocked write storage, synchronous reset, an optional hardwired-zero entry 0, optional write-to-read bypass, and out-of-range address flagging.
- Sits in the CPU datapath between decode (addresses) and the ALU / writeback stage.

Parameters:
- WIDTH, 32, data bits per entry.
- DEPTH, 32, number of entries (2..1024; need not be a power of two).
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).
- NRD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = a same-cycle write to the addressed entry is forwarded to the read data.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- raddr  in  [0:NRD-1][ADDR_W]  read address per port (unpacked array).
- rdata  out  [0:NRD-1][WIDTH]  read data per port (unpacked array, combinational).
- wr_err  out  1  registered pulse: previous write was illegal.
- rd_err  out  NRD  combinational: raddr[i] >= DEPTH.

Behaviour:
- Storage: DEPTH x WIDTH flops, mem[k].
- Reset:
  - rst=1 at a rising edge: every mem[k] <= 0, wr_err <= 0.
  - A write in the same cycle as rst is discarded; rst wins.
  - Reset mid-operation discards all contents. The first cycle after rst deasserts reads all zero.
- Write:
  - At a rising edge with rst=0, we=1, waddr<DEPTH, and not (ZERO_REG && waddr==0): mem[waddr] <= wdata.
  - Write latency is 1 cycle.
- Illegal write: we=1 and (waddr>=DEPTH, or ZERO_REG && waddr==0).
  - No entry changes.
  - wr_err=1 for exactly the following cycle.
  - Otherwise wr_err <= 0 at every edge.
  - Exception: a write to entry 0 with ZERO_REG=1 is NOT an error. It is silently dropped. Only waddr>=DEPTH sets wr_err.
- Read port i, purely combinational, zero latency. Priority order:
  1. raddr[i]>=DEPTH: rdata[i]=0, rd_err[i]=1.
  2. ZERO_REG && raddr[i]==0: rdata[i]=0.
  3. BYPASS && we && !rst && waddr==raddr[i] and the write is legal: rdata[i]=wdata.
  4. Otherwise rdata[i]=mem[raddr[i]].
  - rd_err[i]=0 whenever raddr[i]<DEPTH.
- Simultaneous events:
  - All NRD ports may read the same address in the same cycle; each returns identical data.
  - A read and a write to the same address in one cycle, with BYPASS=0: the read returns the old value. The new value is visible from the next cycle.
  - rst=1 suppresses the bypass. During reset, reads return current mem contents, which are 0 from the cycle after the first reset edge.
- No X propagation: every rdata bit is a defined value for every raddr value, including non-power-of-two DEPTH.
- Width rules:
  - wdata is stored unmodified.
  - Address compare is unsigned across the full ADDR_W bits.
- No internal state beyond mem and wr_err.

Test Plan:
- Reset / write / read (defaults): rst 1 cycle; write mem[5]=0xDEADBEEF; next cycle raddr[0]=5, raddr[1]=6 -> rdata[0]=0xDEADBEEF, rdata[1]=0, wr_err=0.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF; next cycle raddr[0]=0 -> rdata[0]=0, wr_err=0. Repeat with ZERO_REG=0 -> rdata[0]=0xFFFFFFFF.
- Bypass: mem[7]=0x11; same cycle we=1, waddr=7, wdata=0x22, raddr[0]=7 -> rdata[0]=0x22 with BYPASS=1, 0x11 with BYPASS=0; next cycle both read 0x22.
- Out of range (DEPTH=24, ADDR_W=5): write waddr=30 -> wr_err=1 for exactly one cycle, no entry changes; raddr[1]=25 -> rdata[1]=0, rd_err=2'b10.
- Reset priority: fill all 32 entries with index*3; assert rst together with we=1, waddr=3, wdata=0xAA -> next cycle every port reads 0 for all addresses, wr_err=0.
- Multi-port sweep (NRD=4, WIDTH=16): write mem[k]=k^16'h5A5A for k=0..31; read 4 distinct random addresses per cycle for 200 cycles -> match a reference model every cycle.
